// File: rtl/me_control_pkg.sv
// Shared types and constants for the motion-estimation array sequencer.
package me_control_pkg;

  // Block geometry: 16x16 reference block, one PE per horizontal displacement.
  localparam int BLK_LOG2 = 4;
  localparam int NPE      = 1 << BLK_LOG2;
  localparam int BLK_PIX  = NPE * NPE;

  // Step counter covers 4096 RUN steps plus 16 DRAIN steps.
  localparam int T_W = 13;
  typedef logic [T_W-1:0] step_t;

  localparam step_t RUN_LAST = step_t'(4095);
  localparam step_t T_LAST   = step_t'(4111);

  // Address widths: reference is {row, col}, search is {srow, col}.
  localparam int AR_W = 8;
  localparam int AS_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Everything the array and comparator see for one step.
  typedef struct packed {
    logic                mem_en;
    logic [AR_W-1:0]     addr_r;
    logic [AS_W-1:0]     addr_s;
    logic [NPE-1:0]      s1s2mux;
    logic [NPE-1:0]      new_dist;
    logic                cmp_valid;
    logic [BLK_LOG2-1:0] cmp_pe;
    logic [BLK_LOG2-1:0] cmp_v;
  } step_out_t;

endpackage

// File: rtl/me_step_decode.sv
// Combinational map from step counter t (plus phase) to the control values
// the array, memories and comparator need for that step.
module me_step_decode
  import me_control_pkg::*;
(
  input  logic [T_W-1:0] t,
  input  logic           run,
  input  logic           drain,
  output step_out_t      o
);

  logic [BLK_LOG2-1:0] row;
  logic [BLK_LOG2-1:0] col;
  logic [BLK_LOG2-1:0] v;
  logic [4:0]          srow;
  logic                past_first_blk;
  logic                low_in_first_row;

  assign row  = t[7:4];
  assign col  = t[3:0];
  assign v    = t[11:8];
  // Search row never wraps: 0..30 fits in 5 bits.
  assign srow = {1'b0, v} + {1'b0, row};

  // t >= 256 means a full block has streamed through at least one PE.
  assign past_first_blk   = |t[T_W-1:8];
  // t[7:0] < 16: the step where one PE finishes its previous distance.
  assign low_in_first_row = (t[7:4] == 4'd0);

  // Per-step decode; addresses and mux only during RUN, distance control
  // continues through DRAIN so the last column of PEs can finish.
  always_comb begin
    // NOTE: default every field first so no path leaves a latch behind.
    o = '0;
    if (run) begin
      o.mem_en = 1'b1;
      o.addr_r = t[7:0];
      o.addr_s = {srow, col};
      for (int i = 0; i < NPE; i++) begin
        o.s1s2mux[i] = (col >= i[3:0]);
      end
    end
    if (run || drain) begin
      for (int i = 0; i < NPE; i++) begin
        o.new_dist[i] = (t[7:0] == i[7:0]);
      end
      if (past_first_blk && low_in_first_row) begin
        o.cmp_valid = 1'b1;
        o.cmp_pe    = col;
        // The completing distance belongs to the previous vertical offset;
        // in DRAIN v is 0, so this wraps to 15 as intended.
        o.cmp_v     = v - 4'd1;
      end
    end
  end

endmodule

// File: rtl/me_control.sv
// Sequencer for the 16-PE motion-estimation array: walks one full-search pass
// (4096 RUN + 16 DRAIN steps) and drives registered array/memory/comparator
// controls for each step.
module me_control
  import me_control_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_en,
  output logic [AR_W-1:0]     addrR,
  output logic [AS_W-1:0]     addrS1,
  output logic [AS_W-1:0]     addrS2,
  output logic [NPE-1:0]      S1S2mux,
  output logic [NPE-1:0]      newDist,
  output logic                cmp_valid,
  output logic [BLK_LOG2-1:0] cmp_pe,
  output logic [BLK_LOG2-1:0] cmp_v
);

  state_t    state;
  state_t    state_nxt;
  step_t     t;
  step_t     t_nxt;
  logic      run_nxt;
  logic      drain_nxt;
  step_out_t dec;

  // Next state and next step; outputs are decoded from these so that the
  // registered outputs line up with the step held in t.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          t_nxt     = '0;
        end
      end
      RUN: begin
        t_nxt = t + T_W'(1);
        if (t == RUN_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (t == T_LAST) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + T_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  assign run_nxt   = (state_nxt == RUN);
  assign drain_nxt = (state_nxt == DRAIN);

  me_step_decode u_decode (
    .t     (t_nxt),
    .run   (run_nxt),
    .drain (drain_nxt),
    .o     (dec)
  );

  // State, step counter and all registered outputs; reset clears everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state     <= IDLE;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      addrR     <= '0;
      addrS1    <= '0;
      addrS2    <= '0;
      S1S2mux   <= '0;
      newDist   <= '0;
      cmp_valid <= 1'b0;
      cmp_pe    <= '0;
      cmp_v     <= '0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      busy      <= run_nxt || drain_nxt;
      done      <= (state_nxt == DONE);
      mem_en    <= dec.mem_en;
      addrR     <= dec.addr_r;
      addrS1    <= dec.addr_s;
      addrS2    <= dec.addr_s;
      S1S2mux   <= dec.s1s2mux;
      newDist   <= dec.new_dist;
      cmp_valid <= dec.cmp_valid;
      cmp_pe    <= dec.cmp_pe;
      cmp_v     <= dec.cmp_v;
    end
  end

endmodule
